// File: rtl/i2s_mic_rx_if.sv
// Sample stream from the I2S microphone receiver: valid/ready handshake
// plus channel tag and sticky overrun flag.
interface i2s_mic_rx_if #(
    parameter int SAMPLE_W = 18
);
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_chan;
    logic                sample_valid;
    logic                sample_ready;
    logic                overrun;

    modport master (
        output sample_data,
        output sample_chan,
        output sample_valid,
        output overrun,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_chan,
        input  sample_valid,
        input  overrun,
        output sample_ready
    );
endinterface

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for MEMS microphones: generates bclk/ws from mclk,
// deserialises din MSB first and streams samples with overrun tracking.
module i2s_mic_rx #(
    parameter int CLK_DIV     = 4,
    parameter int SLOT_W      = 32,
    parameter int SAMPLE_W    = 18,
    parameter int MODE_STEREO = 1
) (
    input  logic         mclk,
    input  logic         reset,
    input  logic         enable,
    output logic         bclk,
    output logic         ws,
    input  logic         din,
    i2s_mic_rx_if.master s_out
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

    logic [DW-1:0]       r_div_cnt;
    logic [BW-1:0]       r_bit_cnt;
    logic                r_bclk;
    logic                r_ws;
    logic [SAMPLE_W-1:0] r_shift;
    logic [SAMPLE_W-1:0] r_data;
    logic                r_chan;
    logic                r_valid;
    logic                r_ovr;

    logic                w_tick;
    logic                w_rise;
    logic                w_fall;
    logic                w_in_word;
    logic                w_done;
    logic                w_xfer;
    logic [SAMPLE_W-1:0] w_word;

    assign w_tick    = enable && (r_div_cnt == DW'(CLK_DIV - 1));
    assign w_rise    = w_tick && !r_bclk;
    assign w_fall    = w_tick && r_bclk;
    assign w_in_word = (r_bit_cnt != '0) && (r_bit_cnt <= BW'(SAMPLE_W));
    assign w_word    = {r_shift[SAMPLE_W-2:0], din};
    // Right slots are skipped in mono mode without counting as overrun
    assign w_done    = w_rise && (r_bit_cnt == BW'(SAMPLE_W))
                       && ((MODE_STEREO != 0) || !r_ws);
    assign w_xfer    = r_valid && s_out.sample_ready;

    always_ff @(posedge mclk) begin
        if (reset || !enable) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_ws      <= 1'b0;
            r_shift   <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick)
                r_bclk <= ~r_bclk;
            if (w_fall) begin
                if (r_bit_cnt == BW'(SLOT_W - 1)) begin
                    r_bit_cnt <= '0;
                    r_ws      <= ~r_ws;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (w_rise && w_in_word)
                r_shift <= w_word;
        end
    end

    // Output register keeps draining while capture is disabled
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_data  <= '0;
            r_chan  <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || s_out.sample_ready) begin
                r_data  <= w_word;
                r_chan  <= r_ws;
                r_valid <= 1'b1;
            end else begin
                r_ovr   <= 1'b1;
            end
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign bclk                = r_bclk;
    assign ws                  = r_ws;
    assign s_out.sample_data   = r_data;
    assign s_out.sample_chan   = r_chan;
    assign s_out.sample_valid  = r_valid;
    assign s_out.overrun       = r_ovr;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: stereo and mono instances against a frame-arithmetic
// reference model, plus literal latency/data checks.
module tb_i2s_mic_rx;
    localparam int CD  = 2;
    localparam int SW  = 32;
    localparam int SMP = 18;

    logic mclk   = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic din    = 1'b0;
    logic bclk_s, ws_s, bclk_m, ws_m;

    i2s_mic_rx_if #(.SAMPLE_W(SMP)) st_if ();
    i2s_mic_rx_if #(.SAMPLE_W(SMP)) mo_if ();

    i2s_mic_rx #(
        .CLK_DIV(CD), .SLOT_W(SW), .SAMPLE_W(SMP), .MODE_STEREO(1)
    ) u_st (
        .mclk(mclk), .reset(reset), .enable(enable),
        .bclk(bclk_s), .ws(ws_s), .din(din), .s_out(st_if.master)
    );

    i2s_mic_rx #(
        .CLK_DIV(CD), .SLOT_W(SW), .SAMPLE_W(SMP), .MODE_STEREO(0)
    ) u_mo (
        .mclk(mclk), .reset(reset), .enable(enable),
        .bclk(bclk_m), .ws(ws_m), .din(din), .s_out(mo_if.master)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    logic [SMP-1:0] words [256];

    int             n   = 0;
    logic           mv  = 1'b0;
    logic [SMP-1:0] md  = '0;
    logic           mc  = 1'b0;
    logic           mo  = 1'b0;
    logic           mmv = 1'b0;
    logic [SMP-1:0] mmd = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // n = enabled mclk edges since capture (re)started; everything follows from it
    always begin : model
        int             m, s, mm, p;
        logic           dn;
        logic [SMP-1:0] w;
        logic           ch;
        @(posedge mclk);
        dn = 1'b0;
        w  = '0;
        ch = 1'b0;
        if (reset) begin
            n   = 0;
            mv  = 1'b0;
            md  = '0;
            mc  = 1'b0;
            mo  = 1'b0;
            mmv = 1'b0;
            mmd = '0;
        end else begin
            if (enable) begin
                if (n % (2 * CD) == CD - 1) begin
                    m = n / (2 * CD);
                    if (m % SW == SMP) begin
                        s  = m / SW;
                        dn = 1'b1;
                        w  = words[s % 256];
                        ch = (s % 2) == 1;
                    end
                end
                n++;
            end else begin
                n = 0;
            end
            if (dn) begin
                if (!mv || st_if.sample_ready) begin
                    mv = 1'b1;
                    md = w;
                    mc = ch;
                end else begin
                    mo = 1'b1;
                end
            end else if (mv && st_if.sample_ready) begin
                mv = 1'b0;
            end
            if (dn && !ch) begin
                mmv = 1'b1;
                mmd = w;
            end else begin
                mmv = 1'b0;
            end
        end
        #1;
        mm = n / (2 * CD);
        p  = mm % SW;
        if (n % (2 * CD) < CD && p >= 1 && p <= SMP)
            din = words[(mm / SW) % 256][SMP - p];
        else
            din = 1'($urandom);
    end

    always @(negedge mclk) begin
        chk("st_bclk", 32'(bclk_s), 32'((n / CD) % 2));
        chk("st_ws", 32'(ws_s), 32'((n / (2 * CD * SW)) % 2));
        chk("st_valid", 32'(st_if.sample_valid), 32'(mv));
        chk("st_overrun", 32'(st_if.overrun), 32'(mo));
        if (mv) begin
            chk("st_data", 32'(st_if.sample_data), 32'(md));
            chk("st_chan", 32'(st_if.sample_chan), 32'(mc));
        end
        chk("mo_bclk", 32'(bclk_m), 32'((n / CD) % 2));
        chk("mo_ws", 32'(ws_m), 32'((n / (2 * CD * SW)) % 2));
        chk("mo_valid", 32'(mo_if.sample_valid), 32'(mmv));
        chk("mo_overrun", 32'(mo_if.overrun), 32'(0));
        if (mmv) begin
            chk("mo_data", 32'(mo_if.sample_data), 32'(mmd));
            chk("mo_chan", 32'(mo_if.sample_chan), 32'(0));
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic first_left(input logic [SMP-1:0] exp_w, input string tag);
        int cyc;
        cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge mclk);
            if (i == CD - 1)
                chk({tag, "_bclk_pre"}, 32'(bclk_s), 32'(0));
            if (i == CD)
                chk({tag, "_bclk_rise"}, 32'(bclk_s), 32'(1));
            if (st_if.sample_valid) begin
                cyc = i;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(74));
        chk({tag, "_data"}, 32'(st_if.sample_data), 32'(exp_w));
        chk({tag, "_chan"}, 32'(st_if.sample_chan), 32'(0));
    endtask

    initial begin
        int cyc;
        int found;
        for (int i = 0; i < 256; i++)
            words[i] = SMP'($urandom);
        words[0] = 18'h2A5A5;
        words[1] = 18'h15A5A;
        words[2] = 18'h2A5A5;
        words[3] = 18'h15A5A;
        st_if.sample_ready = 1'b1;
        mo_if.sample_ready = 1'b1;

        repeat (3) tick();
        @(negedge mclk);
        chk("rst_valid", 32'(st_if.sample_valid), 32'(0));
        chk("rst_bclk", 32'(bclk_s), 32'(0));
        chk("rst_ws", 32'(ws_s), 32'(0));
        tick();
        reset = 1'b0;
        tick();
        enable = 1'b1;

        first_left(18'h2A5A5, "left0");
        cyc = -1;
        for (int i = 75; i < 400; i++) begin
            @(negedge mclk);
            if (st_if.sample_valid && st_if.sample_chan) begin
                cyc = i;
                break;
            end
        end
        chk("right0_lat", 32'(cyc), 32'(202));
        chk("right0_data", 32'(st_if.sample_data), 32'(18'h15A5A));
        chk("right0_ovr", 32'(st_if.overrun), 32'(0));

        for (int i = 0; i < 600 && n < 230; i++) tick();
        st_if.sample_ready = 1'b0;
        for (int i = 0; i < 600 && n < 468; i++) tick();
        @(negedge mclk);
        chk("hold_valid", 32'(st_if.sample_valid), 32'(1));
        chk("hold_data", 32'(st_if.sample_data), 32'(18'h2A5A5));
        chk("hold_chan", 32'(st_if.sample_chan), 32'(0));
        chk("hold_ovr", 32'(st_if.overrun), 32'(1));
        tick();
        st_if.sample_ready = 1'b1;
        tick();
        tick();
        @(negedge mclk);
        chk("drain_valid", 32'(st_if.sample_valid), 32'(0));
        chk("drain_ovr", 32'(st_if.overrun), 32'(1));

        repeat (1500) begin
            tick();
            st_if.sample_ready = ($urandom % 4) != 0;
        end

        tick();
        st_if.sample_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if ((n / (2 * CD)) % SW == 7 && (n / (2 * CD * SW)) % 2 == 0) begin
                found = 1;
                break;
            end
        end
        chk("bit7_found", 32'(found), 32'(1));
        enable = 1'b0;
        tick();
        @(negedge mclk);
        chk("dis_bclk", 32'(bclk_s), 32'(0));
        chk("dis_ws", 32'(ws_s), 32'(0));
        repeat (19) tick();
        words[0] = 18'h3C0F1;
        enable = 1'b1;
        first_left(18'h3C0F1, "reen");

        tick();
        st_if.sample_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (mv) begin
                found = 1;
                break;
            end
        end
        chk("pend_found", 32'(found), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge mclk);
        chk("rst2_valid", 32'(st_if.sample_valid), 32'(0));
        chk("rst2_data", 32'(st_if.sample_data), 32'(0));
        chk("rst2_ovr", 32'(st_if.overrun), 32'(0));
        chk("rst2_bclk", 32'(bclk_s), 32'(0));
        chk("rst2_ws", 32'(ws_s), 32'(0));

        repeat (800) begin
            tick();
            st_if.sample_ready = ($urandom % 3) != 0;
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
